// File: rtl/cpu_pkg.sv
// Shared CPU datapath definitions: operand widths and the serial shifter FSM encoding.
package cpu_pkg;

  localparam int unsigned WIDTH = 16;
  localparam int unsigned SHW   = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sll_serial_if.sv
// Start/busy/done handshake bundle between the ALU sequencer and the serial left shifter.
interface sll_serial_if;
  import cpu_pkg::*;

  logic             start;
  logic [WIDTH-1:0] hyrja;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] dalja;
  logic             busy;
  logic             done;
  logic             bartja;
  logic             ovf;

  modport master (
    output start, hyrja, shamt,
    input  dalja, busy, done, bartja, ovf
  );

  modport slave (
    input  start, hyrja, shamt,
    output dalja, busy, done, bartja, ovf
  );

endinterface

// File: rtl/sll_serial.sv
// Iterative left shifter: one bit per clock, reporting the last carried-out bit and signed overflow.
module sll_serial
  import cpu_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  sll_serial_if.slave  bus
);

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_sreg;
  logic [SHW-1:0]   r_cnt;
  logic             r_bartja;
  logic             r_ovf;
  logic             r_busy;
  logic             r_done;

  // Next-state decode; start is only honoured in IDLE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE: begin
        if (bus.start) begin
          w_next = (bus.shamt != '0) ? SHIFT : DONE;
        end
      end
      SHIFT: begin
        if (r_cnt == SHW'(1)) begin
          w_next = DONE;
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Datapath; busy/done are registered from the next state so they line up with r_state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sreg   <= '0;
      r_cnt    <= '0;
      r_bartja <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_sreg   <= bus.hyrja;
            r_cnt    <= bus.shamt;
            r_bartja <= 1'b0;
            r_ovf    <= 1'b0;
          end
        end
        SHIFT: begin
          r_sreg   <= {r_sreg[WIDTH-2:0], 1'b0};
          r_bartja <= r_sreg[WIDTH-1];
          r_ovf    <= r_ovf | (r_sreg[WIDTH-1] ^ r_sreg[WIDTH-2]);
          r_cnt    <= r_cnt - SHW'(1);
        end
        default: begin
        end
      endcase
      r_busy <= (w_next != IDLE);
      r_done <= (w_next == DONE);
    end
  end

  assign bus.dalja  = r_sreg;
  assign bus.bartja = r_bartja;
  assign bus.ovf    = r_ovf;
  assign bus.busy   = r_busy;
  assign bus.done   = r_done;

endmodule

// File: tb/tb_sll_serial.sv
// Scoreboard bench for sll_serial: driver pushes model results, monitor checks them on done.
module tb_sll_serial;

  localparam int unsigned P = 10;

  typedef struct {
    logic [15:0] d;
    logic        c;
    logic        v;
    time         t;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  sll_serial_if bus();

  sll_serial dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #(P/2) clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: shift treated as multiplication by 2**s on a wide integer.
  function automatic exp_t model(input logic [15:0] h, input logic [3:0] s);
    exp_t        r;
    logic [31:0] u;
    int          hs;
    longint      p;
    u    = 32'(h) << s;
    hs   = $signed(h);
    p    = longint'(hs) * (longint'(1) << s);
    r.d  = u[15:0];
    r.c  = u[16];
    r.v  = (p > 32767) || (p < -32768);
    r.t  = 0;
    return r;
  endfunction

  task automatic wait_idle();
    int n = 0;
    while ((bus.busy || bus.done) && n < 60) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", 64'(bus.busy || bus.done), 64'(0));
  endtask

  task automatic issue(input logic [15:0] h, input logic [3:0] s);
    exp_t e;
    @(negedge clk);
    wait_idle();
    bus.hyrja = h;
    bus.shamt = s;
    bus.start = 1'b1;
    @(posedge clk);
    e   = model(h, s);
    e.t = $time + time'(s) * P + P/2;
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
    bus.hyrja = 16'($urandom);
    bus.shamt = 4'($urandom);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    if (!reset && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(1), 64'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("dalja",     64'(bus.dalja),  64'(e.d));
        check("bartja",    64'(bus.bartja), 64'(e.c));
        check("ovf",       64'(bus.ovf),    64'(e.v));
        check("done_time", 64'($time),      64'(e.t));
        check("busy_at_done", 64'(bus.busy), 64'(1));
      end
    end
  end

  initial begin
    #(P * 20000);
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    reset     = 1'b1;
    bus.start = 1'b0;
    bus.hyrja = '0;
    bus.shamt = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_dalja",  64'(bus.dalja),  64'(0));
    check("rst_busy",   64'(bus.busy),   64'(0));
    check("rst_done",   64'(bus.done),   64'(0));
    check("rst_bartja", 64'(bus.bartja), 64'(0));
    check("rst_ovf",    64'(bus.ovf),    64'(0));

    // Busy must stay high for shamt+1 cycles.
    issue(16'h0001, 4'd4);
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
    check("busy_len", 64'(n), 64'(5));

    issue(16'hC001, 4'd1);
    issue(16'h4000, 4'd1);
    issue(16'h1234, 4'd0);
    issue(16'h0001, 4'd15);
    issue(16'h8000, 4'd15);

    // A start pulse while shifting must be ignored.
    issue(16'h00FF, 4'd8);
    repeat (2) @(negedge clk);
    bus.start = 1'b1;
    bus.hyrja = 16'hFFFF;
    bus.shamt = 4'd1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_idle();

    // Reset mid-shift clears outputs asynchronously and drops the operation.
    issue(16'h0F0F, 4'd10);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    check("arst_dalja",  64'(bus.dalja),  64'(0));
    check("arst_busy",   64'(bus.busy),   64'(0));
    check("arst_done",   64'(bus.done),   64'(0));
    check("arst_bartja", 64'(bus.bartja), 64'(0));
    check("arst_ovf",    64'(bus.ovf),    64'(0));
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    issue(16'h0003, 4'd2);

    for (int i = 0; i < 25; i++) begin
      issue(16'($urandom), 4'($urandom));
    end

    wait_idle();
    @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
